// File: rtl/mux3_port_arbiter.sv
// mux3_port_arbiter
// Round-robin owner selection for a shared 3:1 datapath mux.
// One requester owns the mux at a time. It keeps ownership until it signals
// done, drops its request, or uses up MAX_HOLD consecutive cycles.
// Grant, select, busy and preempt all come straight from flops, so the mux
// select never glitches and downstream timing sees clean register outputs.

module mux3_port_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [2:0] req_i,
  input  logic [2:0] done_i,
  output logic [2:0] grant_o,
  output logic [1:0] select_o,
  output logic       busy_o,
  output logic       preempt_o
);

  // Two-state controller: nobody owns the mux, or exactly one requester does.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_OWN  = 1'b1;

  // Count value seen on the last cycle an owner may keep the grant.
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  // Requester codes, which double as mux select codes.
  localparam logic [1:0] IDX_0 = 2'd0;
  localparam logic [1:0] IDX_1 = 2'd1;
  localparam logic [1:0] IDX_2 = 2'd2;

  // ---------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------

  // Successor of a requester index in the modulo-3 rotation.
  // The unused code 11 folds back to requester 0.
  function automatic logic [1:0] next_idx(input logic [1:0] idx);
    logic [1:0] nxt;
    case (idx)
      IDX_0:   nxt = IDX_1;
      IDX_1:   nxt = IDX_2;
      IDX_2:   nxt = IDX_0;
      default: nxt = IDX_0;
    endcase
    return nxt;
  endfunction

  // Turn a requester index into its one-hot grant vector.
  function automatic logic [2:0] idx_to_onehot(input logic [1:0] idx);
    logic [2:0] oh;
    case (idx)
      IDX_0:   oh = 3'b001;
      IDX_1:   oh = 3'b010;
      IDX_2:   oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

  // Round-robin search.
  // The search starts just after ptr and wraps around, so ptr itself is
  // tried last. The caller makes sure at least one request bit is set.
  function automatic logic [1:0] rr_pick(input logic [2:0] req,
                                         input logic [1:0] ptr);
    logic [1:0] cand_1;
    logic [1:0] cand_2;
    logic [1:0] cand_3;
    logic [1:0] pick;
    cand_1 = next_idx(ptr);
    cand_2 = next_idx(cand_1);
    cand_3 = next_idx(cand_2);
    if (req[cand_1]) begin
      pick = cand_1;
    end else if (req[cand_2]) begin
      pick = cand_2;
    end else begin
      pick = cand_3;
    end
    return pick;
  endfunction

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [0:0]       state_r;
  logic [2:0]       grant_r;
  logic [1:0]       select_r;
  logic             busy_r;
  logic             preempt_r;
  logic [CNT_W-1:0] hold_cnt_r;
  logic [1:0]       last_r;

  logic [0:0]       state_nxt_s;
  logic [2:0]       grant_nxt_s;
  logic [1:0]       select_nxt_s;
  logic             preempt_nxt_s;
  logic [CNT_W-1:0] hold_cnt_nxt_s;
  logic [1:0]       last_nxt_s;

  logic             any_req_s;
  logic             owner_done_s;
  logic             owner_req_s;
  logic             hold_limit_s;
  logic             release_s;
  logic [1:0]       search_ptr_s;
  logic [1:0]       pick_s;

  // Owner status is masked through the one-hot grant.
  // This means done_i or req_i bits from non-owners can never affect release.
  assign any_req_s    = (req_i != 3'b000);
  assign owner_done_s = ((done_i & grant_r) != 3'b000);
  assign owner_req_s  = ((req_i & grant_r) != 3'b000);
  assign hold_limit_s = (hold_cnt_r == HOLD_LAST);

  // Rotation origin.
  // When idle, the search starts from the last-served requester.
  // On a release in the same cycle, it starts from the owner being released,
  // which is always the code held in select_r while a grant is active.
  // Decide the rotation origin for this cycle's search
  always_comb begin
    search_ptr_s = last_r;
    if (state_r == ST_OWN) begin
      search_ptr_s = select_r;
    end else begin
      search_ptr_s = last_r;
    end
  end

  assign pick_s = rr_pick(req_i, search_ptr_s);

  // Next-state decision: new grant, hold, release-and-regrant, or idle
  always_comb begin
    state_nxt_s    = state_r;
    grant_nxt_s    = grant_r;
    select_nxt_s   = select_r;
    preempt_nxt_s  = 1'b0;
    hold_cnt_nxt_s = hold_cnt_r;
    last_nxt_s     = last_r;
    release_s      = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (any_req_s) begin
          state_nxt_s    = ST_OWN;
          grant_nxt_s    = idx_to_onehot(pick_s);
          select_nxt_s   = pick_s;
          hold_cnt_nxt_s = {CNT_W{1'b0}};
        end else begin
          // select_r is held so the shared mux output stays stable.
          state_nxt_s    = ST_IDLE;
          grant_nxt_s    = 3'b000;
        end
      end

      ST_OWN: begin
        release_s = owner_done_s || !owner_req_s || hold_limit_s;
        if (release_s) begin
          last_nxt_s = select_r;
          // Preempt only when the hold limit alone forced the release.
          // A done or a dropped request on the same cycle counts as a
          // normal release, not a preemption.
          preempt_nxt_s = hold_limit_s && !owner_done_s && owner_req_s;
          if (any_req_s) begin
            state_nxt_s    = ST_OWN;
            grant_nxt_s    = idx_to_onehot(pick_s);
            select_nxt_s   = pick_s;
            hold_cnt_nxt_s = {CNT_W{1'b0}};
          end else begin
            state_nxt_s    = ST_IDLE;
            grant_nxt_s    = 3'b000;
            hold_cnt_nxt_s = {CNT_W{1'b0}};
          end
        end else begin
          hold_cnt_nxt_s = hold_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end

      default: begin
        // Recover from an illegal state encoding by dropping any grant.
        state_nxt_s    = ST_IDLE;
        grant_nxt_s    = 3'b000;
        hold_cnt_nxt_s = {CNT_W{1'b0}};
      end
    endcase
  end

  // Register arbiter state and outputs; synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_r    <= ST_IDLE;
      grant_r    <= 3'b000;
      select_r   <= IDX_0;
      busy_r     <= 1'b0;
      preempt_r  <= 1'b0;
      hold_cnt_r <= {CNT_W{1'b0}};
      last_r     <= IDX_2;
    end else begin
      state_r    <= state_nxt_s;
      grant_r    <= grant_nxt_s;
      select_r   <= select_nxt_s;
      busy_r     <= (grant_nxt_s != 3'b000);
      preempt_r  <= preempt_nxt_s;
      hold_cnt_r <= hold_cnt_nxt_s;
      last_r     <= last_nxt_s;
    end
  end

  assign grant_o   = grant_r;
  assign select_o  = select_r;
  assign busy_o    = busy_r;
  assign preempt_o = preempt_r;

endmodule
